i2s_tdm_rx: RTL
===============

Name: i2s_tdm_rx

Overview:
Parametrised successor to the i2s receiver. It is the I2S/TDM clock master for the ADC front end and generates scki, bck and lrck. It deserialises CH slots per frame in either I2S or left-justified mode. Captured samples are buffered in a DEPTH-entry FIFO and handed to the windowing/FFT path over a valid/ready stream, with a sticky overflow flag.

Parameters:
WIDTH, 24, sample bits captured per slot (MSB first, two's complement, passed through raw)
SLOT, 32, bck periods per slot; SLOT >= WIDTH+1
CH, 2, slots per frame; even, 2..8 (2 = standard stereo I2S)
DIV, 2, clk cycles per bck half-period; >= 1
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (reset=0 resets the block)
en  in  1  run enable
mode  in  1  0 = I2S (one-bit delay after slot start), 1 = left-justified
din  in  1  serial data from ADC
scki  out  1  ADC system clock = clk/2, toggles every clk while en=1
bck  out  1  bit clock, period 2*DIV clk
lrck  out  1  frame clock: low for slots 0..CH/2-1, high for slots CH/2..CH-1
sample  out  WIDTH  FIFO head data
sample_ch  out  max(1,$clog2(CH))  slot index of the FIFO head
valid  out  1  FIFO non-empty
ready  in  1  consumer accepts the head when valid && ready at a clk edge
overflow  out  1  sticky: a sample was dropped
ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (reset=0, asynchronous): scki=bck=lrck=0, valid=0, sample=0, sample_ch=0, overflow=0. All counters are 0, the FIFO is empty and the shift register is 0. Reset mid-frame discards everything.
- Counters:
  - div counter 0..DIV-1. When it wraps, bck toggles.
  - bit counter 0..SLOT-1 advances on each bck falling toggle.
  - slot counter 0..CH-1 advances when the bit counter wraps.
  - lrck and slot/bit changes are registered on the same edge as bck falling.
- Capture:
  - din is sampled on the clk edge where bck goes 0->1.
  - mode=0: bits at bit counter 1..WIDTH are shifted in. mode=1: bits at 0..WIDTH-1 are shifted in. All other bits are ignored.
  - mode is latched only while en=0. Changes while en=1 are ignored until the next enable.
- Push: the clk edge after the capture of the last bit pushes {shift, slot} into the FIFO. valid is asserted on the following edge, so the sample appears exactly 2 clk after the final capture edge when the FIFO was empty.
- FIFO:
  - Registered head; in-order by slot.
  - Pop on valid && ready.
  - Push when full with no pop: the sample is dropped and overflow is set on the same edge.
  - Push when full with a pop on the same edge: accepted, no drop.
  - Push and pop when empty: the push is accepted and valid rises next edge (no bypass).
- overflow: set has priority over ovf_clr on the same edge. Otherwise ovf_clr=1 clears it.
- en=0 (synchronous):
  - Next edge: counters, bck, lrck and scki are cleared to 0 and the partial sample is discarded.
  - FIFO contents stay poppable.
  - Re-enabling starts at slot 0, bit 0 with lrck=0. The first bck rise occurs DIV clk after the en rise.
- Frame period = 2*DIV*SLOT*CH clk (256 for defaults).

Test Plan:
- Reset: assert reset=0 mid-slot with 2 samples queued -> immediately scki=bck=lrck=valid=overflow=0. After release with en=1, first bck rise at DIV clk.
- Stereo I2S, defaults, ready=1: bench drives din on bck falling with left=24'h123456, right=24'hABCDEF. Required:
  - outputs (ch0, 24'h123456) then (ch1, 24'hABCDEF);
  - bck period 4 clk;
  - lrck toggles every 128 clk;
  - each valid exactly 2 clk after the final capture edge.
- TDM LJ: CH=4, mode=1, slots 24'h000001, 24'h800000, 24'h7FFFFF, 24'hFFFFFF -> sample_ch 0..3 with those values in order. lrck is high for slots 2-3.
- Overflow: DEPTH=4, ready=0 for 5 samples -> first 4 retained and 5th dropped, overflow=1. Then ready=1 drains 4 in order. ovf_clr pulse gives overflow=0.
- Full pop+push: FIFO full, ready=1 held on the push edge -> no drop, overflow stays 0, order preserved.
- en=0 mid-slot with mode flipped while en=1 -> bck/lrck low the next clk, no partial sample pushed, mode change ignored. Re-enable with mode=1 -> left-justified capture from slot 0.

Source files
------------

// File: rtl/i2s_tdm_rx.sv
// I2S / TDM receive master: generates scki/bck/lrck, deserialises CH slots
// per frame and queues {slot, sample} in a registered-head FIFO.
`timescale 1ns/1ps
module i2s_tdm_rx #(
  parameter int WIDTH = 24,
  parameter int SLOT  = 32,
  parameter int CH    = 2,
  parameter int DIV   = 2,
  parameter int DEPTH = 4,
  localparam int CW   = (CH > 2) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             din,
  output logic             scki,
  output logic             bck,
  output logic             lrck,
  output logic [WIDTH-1:0] sample,
  output logic [CW-1:0]    sample_ch,
  output logic             valid,
  input  logic             ready,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(SLOT);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT - 1);
  localparam logic [BW-1:0] I2S_LAST  = BW'(WIDTH);
  localparam logic [BW-1:0] LJ_LAST   = BW'(WIDTH - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(CH - 1);
  localparam logic [CW-1:0] SLOT_HALF = CW'(CH / 2);
  localparam logic [NW-1:0] FULL_N    = NW'(DEPTH);

  logic [DW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CW-1:0]       slot_q, slot_d;
  logic                bck_q, bck_d;
  logic                lrck_q, lrck_d;
  logic                scki_q, scki_d;
  logic                mode_q, mode_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic                pend_q, pend_d;
  logic [CW-1:0]       pch_q, pch_d;
  logic [WIDTH+CW-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0]       cnt_q, cnt_d, total;
  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    sample_q, sample_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic                ovf_q, ovf_d;

  logic tick, rise, fall, in_win, last, cap;
  logic pop, full, acc, drop, load;

  assign tick = (div_q == DIV_LAST);
  assign rise = en & tick & ~bck_q;
  assign fall = en & tick & bck_q;

  // I2S frames the sample one bck after slot start; LJ starts at bit 0
  assign in_win = mode_q ? (bit_q <= LJ_LAST)
                         : (bit_q != '0 && bit_q <= I2S_LAST);
  assign last   = mode_q ? (bit_q == LJ_LAST) : (bit_q == I2S_LAST);
  assign cap    = rise & in_win;

  always_comb begin
    div_d  = div_q;
    bit_d  = bit_q;
    slot_d = slot_q;
    bck_d  = bck_q;
    lrck_d = lrck_q;
    scki_d = scki_q;
    mode_d = mode_q;
    if (!en) begin
      div_d  = '0;
      bit_d  = '0;
      slot_d = '0;
      bck_d  = 1'b0;
      lrck_d = 1'b0;
      scki_d = 1'b0;
      mode_d = mode;
    end else begin
      scki_d = ~scki_q;
      div_d  = tick ? '0 : div_q + 1'b1;
      if (tick) bck_d = ~bck_q;
      if (fall) begin
        if (bit_q == BIT_LAST) begin
          bit_d  = '0;
          slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end else begin
          bit_d = bit_q + 1'b1;
        end
        lrck_d = (slot_d >= SLOT_HALF);
      end
    end
  end

  always_comb begin
    shift_d = '0;
    if (en) shift_d = cap ? {shift_q[WIDTH-2:0], din} : shift_q;
    pend_d = cap & last;
    pch_d  = (cap & last) ? slot_q : pch_q;
  end

  assign pop   = valid_q & ready;
  assign total = cnt_q + NW'(valid_q);
  assign full  = (total == FULL_N);
  assign acc   = pend_q & (~full | pop);
  assign drop  = pend_q & full & ~pop;
  assign load  = (~valid_q | pop) & (cnt_q != '0);

  // the head register refills only from storage, so a push never bypasses
  always_comb begin
    valid_d  = valid_q;
    sample_d = sample_q;
    ch_d     = ch_q;
    if (~valid_q | pop) valid_d = (cnt_q != '0);
    if (load) {ch_d, sample_d} = mem_q[rd_q];
    rd_d  = rd_q + AW'(load);
    wr_d  = wr_q + AW'(acc);
    cnt_d = cnt_q + NW'(acc) - NW'(load);
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_q] <= {pch_q, shift_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q    <= '0;
      bit_q    <= '0;
      slot_q   <= '0;
      bck_q    <= 1'b0;
      lrck_q   <= 1'b0;
      scki_q   <= 1'b0;
      mode_q   <= 1'b0;
      shift_q  <= '0;
      pend_q   <= 1'b0;
      pch_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      sample_q <= '0;
      ch_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      slot_q   <= slot_d;
      bck_q    <= bck_d;
      lrck_q   <= lrck_d;
      scki_q   <= scki_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      pend_q   <= pend_d;
      pch_q    <= pch_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
      ch_q     <= ch_d;
      ovf_q    <= ovf_d;
    end
  end

  assign scki      = scki_q;
  assign bck       = bck_q;
  assign lrck      = lrck_q;
  assign sample    = sample_q;
  assign sample_ch = ch_q;
  assign valid     = valid_q;
  assign overflow  = ovf_q;

endmodule
